// File: rtl/add_long.sv
// add_long: multi-limb base-MAX adder, one limb per clock, LSB limb first.
// Operands are latched on an accepted start. The sum is held with finish
// high until the next accepted start.
module add_long #(
  parameter int WIDTH = 16,
  parameter int L     = 4,
  parameter int MAX   = 10000
) (
  input  logic                    ck,
  input  logic                    rst,
  input  logic                    start,
  input  logic [L-1:0][WIDTH-1:0] a,
  input  logic [L-1:0][WIDTH-1:0] b,
  output logic                    busy,
  output logic                    finish,
  output logic                    carry_out,
  output logic [L-1:0][WIDTH-1:0] c
);

  localparam int IW = (L > 1) ? $clog2(L) : 1;
  localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MAX);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    r_state, w_next;
  logic [L-1:0][WIDTH-1:0]   r_a, r_b, r_c;
  logic [IW-1:0]             r_idx;
  logic                      r_carry, r_busy, r_finish, r_cout;
  logic                      w_accept, w_step, w_last, w_ge;
  logic [WIDTH:0]            w_sum, w_diff;
  logic [WIDTH-1:0]          w_limb;

  // Limb adder: the sum keeps WIDTH+1 bits so it is never truncated before
  // the radix comparison; only the selected result is cut back to WIDTH.
  always_comb begin
    w_sum  = {1'b0, r_a[r_idx]} + {1'b0, r_b[r_idx]} + {{WIDTH{1'b0}}, r_carry};
    w_ge   = (w_sum >= MAXV);
    w_diff = w_sum - MAXV;
    w_limb = w_ge ? WIDTH'(w_diff) : WIDTH'(w_sum);
    w_last = (r_idx == IW'(L-1));
  end

  // State register.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next state and per-cycle control; start is only honoured in IDLE/DONE.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_step   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand latch, limb index, ripple carry and status flags.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_busy   <= 1'b0;
      r_finish <= 1'b0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_busy   <= 1'b1;
      r_finish <= 1'b0;
      r_cout   <= 1'b0;
    end else if (w_step) begin
      r_carry <= w_ge;
      if (w_last) begin
        r_cout   <= w_ge;
        r_busy   <= 1'b0;
        r_finish <= 1'b1;
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  // Result limbs: each limb register loads only on its own step, so limbs not
  // yet reached in the current operation keep their previous values.
  for (genvar k = 0; k < L; k++) begin : g_limb
    always_ff @(posedge ck or negedge rst) begin
      if (!rst)                                r_c[k] <= '0;
      else if (w_step && (r_idx == IW'(k)))    r_c[k] <= w_limb;
    end
  end

  assign busy      = r_busy;
  assign finish    = r_finish;
  assign carry_out = r_cout;
  assign c         = r_c;

endmodule

// File: tb/tb_add_long.sv
// Directed bench for add_long (WIDTH=16, L=4, MAX=10000).
module tb_add_long;

  logic               ck, rst, start;
  logic [3:0][15:0]   a, b, c;
  logic               busy, finish, carry_out;

  int checks = 0;
  int errors = 0;

  add_long #(.WIDTH(16), .L(4), .MAX(10000)) dut (
    .ck(ck), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .finish(finish), .carry_out(carry_out), .c(c)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] pk(input int l3, input int l2, input int l1, input int l0);
    pk = {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Drive start for one edge (E0); returns at the negedge after E0 (P0).
  task automatic do_start(input logic [63:0] av, input logic [63:0] bv);
    @(negedge ck);
    a = av; b = bv; start = 1'b1;
    @(negedge ck);
    start = 1'b0;
  endtask

  // Full operation: finish/carry_out low from P0, busy high for exactly 4
  // cycles, then finish high with the expected sum at P4.
  task automatic run_op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                        input logic [63:0] ec, input logic ecout);
    int nb;
    nb = 0;
    do_start(av, bv);
    chk({tag, "_cout_p0"}, 64'(carry_out), 64'(0));
    for (int i = 0; i < 4; i++) begin
      if (busy) nb++;
      chk({tag, "_fin_low"}, 64'(finish), 64'(0));
      @(negedge ck);
    end
    chk({tag, "_busy_cyc"}, 64'(nb), 64'(4));
    chk({tag, "_fin"}, 64'(finish), 64'(1));
    chk({tag, "_busy_end"}, 64'(busy), 64'(0));
    chk({tag, "_c"}, c, ec);
    chk({tag, "_cout"}, 64'(carry_out), 64'(ecout));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; a = '0; b = '0;
    @(negedge ck);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_fin", 64'(finish), 64'(0));
    chk("rst_cout", 64'(carry_out), 64'(0));
    chk("rst_c", c, 64'(0));
    rst = 1'b1;
    @(negedge ck);
    chk("idle_busy", 64'(busy), 64'(0));

    // Simple sum.
    run_op("basic", pk(0,0,0,1234), pk(0,0,0,4321), pk(0,0,0,5555), 1'b0);

    // Ripple carry through every limb, with a mid-chain look at limb 0.
    do_start(pk(9999,9999,9999,9999), pk(0,0,0,1));
    chk("rip_fin_p0", 64'(finish), 64'(0));
    @(negedge ck);
    chk("rip_c0_mid", 64'(c[0]), 64'(0));
    chk("rip_busy_mid", 64'(busy), 64'(1));
    repeat (3) @(negedge ck);
    chk("rip_fin", 64'(finish), 64'(1));
    chk("rip_c", c, pk(0,0,0,0));
    chk("rip_cout", 64'(carry_out), 64'(1));

    // Restart from DONE: finish and carry_out drop on the start edge.
    run_op("redo", pk(0,0,0,1), pk(0,0,0,2), pk(0,0,0,3), 1'b0);

    // Mixed carries: 10000 -> 0, 9999+1 -> 0, 5000+4999+1 -> 0, 1+2+1 = 4.
    run_op("mixed", pk(1,5000,9999,9000), pk(2,4999,0,1000), pk(4,0,0,0), 1'b0);

    // Start and operand changes during RUN are ignored.
    do_start(pk(0,0,0,10), pk(0,0,0,20));
    @(negedge ck);
    start = 1'b1; a = pk(0,0,0,7777); b = pk(1,1,1,1);
    @(negedge ck);
    start = 1'b0;
    @(negedge ck);
    chk("ign_fin_p3", 64'(finish), 64'(0));
    @(negedge ck);
    chk("ign_fin", 64'(finish), 64'(1));
    chk("ign_c", c, pk(0,0,0,30));
    chk("ign_cout", 64'(carry_out), 64'(0));
    @(negedge ck);
    chk("ign_hold_fin", 64'(finish), 64'(1));
    chk("ign_hold_busy", 64'(busy), 64'(0));

    // Asynchronous reset between edges in the middle of RUN.
    do_start(pk(9999,9999,9999,9999), pk(0,0,0,1));
    @(negedge ck);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_fin", 64'(finish), 64'(0));
    chk("arst_cout", 64'(carry_out), 64'(0));
    chk("arst_c", c, 64'(0));
    @(negedge ck);
    rst = 1'b1;
    @(negedge ck);
    chk("arst_idle", 64'(busy), 64'(0));
    // 10000 -> 0 c1; 5000+5000+1 -> 1 c1; 0+0+1 -> 1; 0.
    run_op("post_rst", pk(0,0,5000,5000), pk(0,0,5000,5000), pk(0,1,1,0), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
